bus_rr_mux: RTL and testbench
=============================

Name: bus_rr_mux

Overview:
- Parametrised N-channel bus multiplexer with registered outputs and round-robin arbitration. Successor to the fixed 3-input 32-bit combinational mux.
- Several bus masters (CPU, DMA, test port) raise requests. The block grants one master at a time and forwards that master's write flag, address and data to the shared RAM-side bus.
- Bursts are supported, with a fairness limit on burst length.

Parameters:
- N_CH, 3, number of master channels (2..8)
- DATA_W, 32, data width
- ADDR_W, 8, address width
- MAX_BURST, 4, granted cycles after which the grant is revoked if another channel is waiting (>=1)

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- m_req  in  N_CH  per-channel request
- m_wr  in  N_CH  per-channel write flag (1=write, 0=read)
- m_addr  in  N_CH*ADDR_W  packed addresses; channel i at [i*ADDR_W +: ADDR_W]
- m_dout  in  N_CH*DATA_W  packed write data; channel i at [i*DATA_W +: DATA_W]
- m_grant  out  N_CH  one-hot grant, registered
- s_valid  out  1  bus cycle valid, registered
- s_wr  out  1  forwarded write flag, registered
- s_addr  out  ADDR_W  forwarded address, registered
- s_dout  out  DATA_W  forwarded data, registered
- s_owner  out  clog2(N_CH)  index of current owner, registered

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, on reset_n.
- Reset values:
  - State = IDLE, rr_ptr = 0, burst_cnt = 0.
  - m_grant, s_valid, s_wr, s_addr, s_dout and s_owner are all 0.
  - Reset asserted mid-burst clears everything immediately. The burst is not resumed.
- State IDLE:
  - If m_req is nonzero, the winner is the first set bit searching upward from rr_ptr, wrapping modulo N_CH.
  - At the next edge: state = GRANT, m_grant = onehot(winner), s_owner = winner, burst_cnt = 1.
  - The same edge captures the winner's m_wr, m_addr and m_dout into s_wr, s_addr and s_dout, and sets s_valid = 1.
  - Latency from req high to s_valid high is 1 cycle.
  - If m_req is zero, the block stays in IDLE with s_valid = 0.
- State GRANT, evaluated each edge with g = granted channel and others = m_req with bit g cleared:
  - Release (m_req[g] = 0): state = IDLE, m_grant = 0, s_valid = 0, rr_ptr = (g+1) mod N_CH. s_wr, s_addr and s_dout hold their last values.
  - Forced release (burst_cnt == MAX_BURST and others != 0): same actions as release.
  - Continue (all other cases): capture channel g's current inputs, s_valid = 1, burst_cnt = min(burst_cnt+1, MAX_BURST). A saturated count keeps the grant while nobody else is waiting.
- Handover always inserts exactly one IDLE cycle (s_valid = 0) between different grants, and also between consecutive grants to the same channel.
- m_grant is never more than one-hot. A non-granted channel's inputs never reach the s_* outputs.
- Request changes on non-granted channels during GRANT have no effect until the next IDLE cycle.
- rr_ptr changes only on release. A channel that re-requests right after release has the lowest priority among contenders.

Decomposition:
- Package bus_pkg holds:
  - State enum {IDLE, GRANT}.
  - Default widths DATA_W_DEF=32 and ADDR_W_DEF=8.
  - A function for one-hot encoding.
- Sub-module rr_arbiter: purely combinational. Takes req[N_CH] and ptr and returns winner index plus any_req. It is instantiated once, and bus_rr_mux owns all registers.

Test Plan:
1. Reset: hold reset_n=0 with m_req=3'b111 -> all outputs 0. Release at t=20ns -> first grant goes to ch0 with s_valid=1 one cycle later.
2. Single write: ch1 req=1, wr=1, addr=8'h10, dout=32'h2222_2222 for 1 cycle -> next cycle m_grant=3'b010, s_addr=8'h10, s_dout=32'h2222_2222, s_valid=1. The following cycle is IDLE with s_valid=0.
3. Round-robin: all three channels request 1-cycle transfers continuously (d0=32'h1111_1111, d1=32'h2222_2222, d2=32'h3333_3333) -> s_owner sequence 0,1,2,0,... with an IDLE gap between each.
4. Burst limit: ch0 holds req for 10 cycles while ch2 requests -> ch0 gets exactly 4 valid cycles, one IDLE cycle follows, then ch2 is granted.
5. Uncontended burst: ch0 holds req for 10 cycles alone -> 10 consecutive s_valid cycles with no forced release. Grant drops the cycle after req falls.
6. Reset mid-burst: pull reset_n low during a ch1 grant -> m_grant and s_valid drop asynchronously. After release, rr_ptr=0, so ch0 wins if ch0 and ch1 both request.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared types and helpers for the round-robin bus multiplexer.
package bus_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 8;
   localparam int MAX_CH     = 8;

   function automatic logic [MAX_CH-1:0] onehot(input logic [2:0] idx);
      onehot = MAX_CH'(1) << idx;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
module rr_arbiter #(
   parameter int N_CH = 3,
   parameter int OW   = $clog2(N_CH)
) (
   input  logic [N_CH-1:0] req,
   input  logic [OW-1:0]   ptr,
   output logic [OW-1:0]   winner,
   output logic            any_req
);

   always_comb begin
      winner  = '0;
      any_req = 1'b0;
      for (int i = 0; i < N_CH; i++) begin
         if (!any_req && req[(int'(ptr) + i) % N_CH]) begin
            any_req = 1'b1;
            winner  = OW'((int'(ptr) + i) % N_CH);
         end
      end
   end

endmodule

// File: rtl/bus_rr_mux.sv
// N-channel bus mux with round-robin grant, registered outputs and a burst
// fairness limit.
//
// state | meaning
// IDLE  | no owner; next edge grants the round-robin winner if anyone requests
// GRANT | s_owner owns the bus; each edge continues or releases
module bus_rr_mux
   import bus_pkg::*;
#(
   parameter int N_CH      = 3,
   parameter int DATA_W    = DATA_W_DEF,
   parameter int ADDR_W    = ADDR_W_DEF,
   parameter int MAX_BURST = 4
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [N_CH-1:0]           m_req,
   input  logic [N_CH-1:0]           m_wr,
   input  logic [N_CH*ADDR_W-1:0]    m_addr,
   input  logic [N_CH*DATA_W-1:0]    m_dout,
   output logic [N_CH-1:0]           m_grant,
   output logic                      s_valid,
   output logic                      s_wr,
   output logic [ADDR_W-1:0]         s_addr,
   output logic [DATA_W-1:0]         s_dout,
   output logic [$clog2(N_CH)-1:0]   s_owner
);

   localparam int OW = $clog2(N_CH);
   localparam int BW = $clog2(MAX_BURST + 1);

   state_t          state, state_nxt;
   logic [OW-1:0]   rr_ptr;
   logic [OW-1:0]   winner;
   logic            any_req;
   logic [BW-1:0]   burst_cnt;
   logic [N_CH-1:0] others;
   logic            own_req;
   logic            burst_full;
   logic            release_bus;
   logic            start;
   logic            capture;
   logic [OW-1:0]   sel;
   logic [N_CH-1:0] grant_nxt;
   logic [OW-1:0]   ptr_nxt;

   rr_arbiter #(
      .N_CH (N_CH),
      .OW   (OW)
   ) u_arb (
      .req     (m_req),
      .ptr     (rr_ptr),
      .winner  (winner),
      .any_req (any_req)
   );

   assign others      = m_req & ~m_grant;
   assign own_req     = m_req[s_owner];
   assign burst_full  = (burst_cnt == BW'(MAX_BURST));
   // A saturated burst only yields when someone else is actually waiting.
   assign release_bus = (state == GRANT) && (!own_req || (burst_full && (|others)));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (any_req)     state_nxt = GRANT;
         GRANT:   if (release_bus) state_nxt = IDLE;
         default:                  state_nxt = IDLE;
      endcase
   end

   always_comb begin
      start     = (state == IDLE) && any_req;
      capture   = start || ((state == GRANT) && !release_bus);
      sel       = start ? winner : s_owner;
      grant_nxt = N_CH'(onehot(3'(winner)));
      ptr_nxt   = (s_owner == OW'(N_CH - 1)) ? '0 : s_owner + OW'(1);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_grant   <= '0;
         s_owner   <= '0;
         rr_ptr    <= '0;
         burst_cnt <= '0;
         s_valid   <= 1'b0;
      end else begin
         s_valid <= capture;
         if (start) begin
            m_grant   <= grant_nxt;
            s_owner   <= winner;
            burst_cnt <= BW'(1);
         end else if (release_bus) begin
            m_grant   <= '0;
            rr_ptr    <= ptr_nxt;
            burst_cnt <= '0;
         end else if ((state == GRANT) && !burst_full) begin
            burst_cnt <= burst_cnt + BW'(1);
         end
      end
   end

   // Data path holds its last beat on release; only the owner's lane is sampled.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s_wr   <= 1'b0;
         s_addr <= '0;
         s_dout <= '0;
      end else if (capture) begin
         s_wr   <= m_wr[sel];
         s_addr <= m_addr[int'(sel)*ADDR_W +: ADDR_W];
         s_dout <= m_dout[int'(sel)*DATA_W +: DATA_W];
      end
   end

endmodule

// File: tb/tb_bus_rr_mux.sv
// Directed bench for bus_rr_mux with a scoreboard of expected bus beats.
module tb_bus_rr_mux;

   localparam int N  = 3;
   localparam int DW = 32;
   localparam int AW = 8;

   logic            clk = 1'b0;
   logic            reset_n;
   logic [N-1:0]    m_req;
   logic [N-1:0]    m_wr;
   logic [N*AW-1:0] m_addr;
   logic [N*DW-1:0] m_dout;
   logic [N-1:0]    m_grant;
   logic            s_valid;
   logic            s_wr;
   logic [AW-1:0]   s_addr;
   logic [DW-1:0]   s_dout;
   logic [1:0]      s_owner;

   typedef struct packed {
      logic [1:0]  owner;
      logic        wr;
      logic [7:0]  addr;
      logic [31:0] dout;
   } beat_t;

   beat_t sb[$];
   int    checks = 0;
   int    errors = 0;
   int    exp_seq[6] = '{2, 0, 1, 2, 0, 1};

   bus_rr_mux #(
      .N_CH      (N),
      .DATA_W    (DW),
      .ADDR_W    (AW),
      .MAX_BURST (4)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .m_req   (m_req),
      .m_wr    (m_wr),
      .m_addr  (m_addr),
      .m_dout  (m_dout),
      .m_grant (m_grant),
      .s_valid (s_valid),
      .s_wr    (s_wr),
      .s_addr  (s_addr),
      .s_dout  (s_dout),
      .s_owner (s_owner)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_ch(input int ch, input logic wr, input logic [7:0] a, input logic [31:0] d);
      m_wr[ch]           = wr;
      m_addr[ch*AW +: AW] = a;
      m_dout[ch*DW +: DW] = d;
   endtask

   task automatic expect_beat(input int ch);
      beat_t b;
      b.owner = 2'(ch);
      b.wr    = m_wr[ch];
      b.addr  = m_addr[ch*AW +: AW];
      b.dout  = m_dout[ch*DW +: DW];
      sb.push_back(b);
   endtask

   task automatic tick();
      beat_t b;
      @(posedge clk);
      #1;
      if (s_valid) begin
         if (sb.size() == 0) begin
            chk("unexpected_valid", 64'(s_valid), 64'(0));
         end else begin
            b = sb.pop_front();
            chk("beat_owner", 64'(s_owner), 64'(b.owner));
            chk("beat_grant", 64'(m_grant), 64'(3'b001 << b.owner));
            chk("beat_wr",    64'(s_wr),    64'(b.wr));
            chk("beat_addr",  64'(s_addr),  64'(b.addr));
            chk("beat_dout",  64'(s_dout),  64'(b.dout));
         end
      end else if (sb.size() != 0) begin
         b = sb.pop_front();
         chk("missing_beat", 64'(s_valid), 64'(1));
      end
   endtask

   initial begin
      // 1: reset with all channels requesting
      reset_n = 1'b0;
      m_req   = 3'b111;
      m_wr    = '0;
      m_addr  = '0;
      m_dout  = '0;
      set_ch(0, 1'b1, 8'h01, 32'h0000_00A0);
      set_ch(1, 1'b0, 8'h02, 32'h0000_00A1);
      set_ch(2, 1'b1, 8'h03, 32'h0000_00A2);
      #12;
      chk("rst_grant", 64'(m_grant), 64'(0));
      chk("rst_valid", 64'(s_valid), 64'(0));
      chk("rst_wr",    64'(s_wr),    64'(0));
      chk("rst_addr",  64'(s_addr),  64'(0));
      chk("rst_dout",  64'(s_dout),  64'(0));
      chk("rst_owner", 64'(s_owner), 64'(0));
      #8;
      reset_n = 1'b1;
      expect_beat(0);
      tick();
      chk("t1_first_grant", 64'(m_grant), 64'(3'b001));
      m_req = 3'b000;
      tick();
      chk("t1_release_valid", 64'(s_valid), 64'(0));

      // 2: single write from ch1
      set_ch(1, 1'b1, 8'h10, 32'h2222_2222);
      m_req = 3'b010;
      expect_beat(1);
      tick();
      chk("t2_grant", 64'(m_grant), 64'(3'b010));
      m_req = 3'b000;
      tick();
      chk("t2_idle_valid", 64'(s_valid), 64'(0));
      chk("t2_idle_grant", 64'(m_grant), 64'(0));

      // 3: round robin with one-beat masters (pointer now at ch2)
      set_ch(0, 1'b0, 8'h20, 32'h1111_1111);
      set_ch(1, 1'b1, 8'h21, 32'h2222_2222);
      set_ch(2, 1'b0, 8'h22, 32'h3333_3333);
      m_req = 3'b111;
      for (int k = 0; k < 6; k++) begin
         expect_beat(exp_seq[k]);
         tick();
         m_req[exp_seq[k]] = 1'b0;
         tick();
         chk("t3_gap_valid", 64'(s_valid), 64'(0));
         m_req[exp_seq[k]] = 1'b1;
      end
      m_req = 3'b000;

      // 4: burst limit, ch2 waiting while ch0 bursts
      m_req = 3'b001;
      set_ch(0, 1'b1, 8'h40, 32'hA000_0000);
      expect_beat(0);
      tick();
      m_req[2] = 1'b1;
      for (int k = 1; k < 4; k++) begin
         set_ch(0, 1'b1, 8'(8'h40 + k), 32'hA000_0000 + k);
         expect_beat(0);
         tick();
      end
      set_ch(0, 1'b1, 8'h44, 32'hA000_0004);
      tick();
      chk("t4_forced_valid", 64'(s_valid), 64'(0));
      chk("t4_forced_grant", 64'(m_grant), 64'(0));
      expect_beat(2);
      tick();
      chk("t4_ch2_grant", 64'(m_grant), 64'(3'b100));
      m_req[2] = 1'b0;
      tick();
      chk("t4_ch2_release", 64'(s_valid), 64'(0));
      expect_beat(0);
      tick();
      chk("t4_ch0_regrant", 64'(m_grant), 64'(3'b001));
      m_req = 3'b000;
      tick();
      chk("t4_end_valid", 64'(s_valid), 64'(0));

      // 5: uncontended burst of ten beats
      m_req = 3'b001;
      for (int k = 0; k < 10; k++) begin
         set_ch(0, 1'b0, 8'(8'h60 + k), 32'hB000_0000 + k);
         set_ch(2, 1'b1, 8'(8'hE0 + k), 32'hEEEE_0000 + k);
         expect_beat(0);
         tick();
      end
      m_req = 3'b000;
      tick();
      chk("t5_drop_valid", 64'(s_valid), 64'(0));
      chk("t5_drop_grant", 64'(m_grant), 64'(0));
      chk("t5_hold_addr",  64'(s_addr),  64'(8'h69));
      chk("t5_hold_dout",  64'(s_dout),  64'(32'hB000_0009));

      // 6: asynchronous reset during a ch1 grant
      set_ch(1, 1'b1, 8'h70, 32'hC0C0_C0C0);
      m_req = 3'b010;
      expect_beat(1);
      tick();
      chk("t6_ch1_grant", 64'(m_grant), 64'(3'b010));
      #2;
      reset_n = 1'b0;
      #1;
      chk("t6_async_grant", 64'(m_grant), 64'(0));
      chk("t6_async_valid", 64'(s_valid), 64'(0));
      chk("t6_async_owner", 64'(s_owner), 64'(0));
      set_ch(0, 1'b0, 8'h71, 32'hD0D0_D0D0);
      m_req = 3'b011;
      tick();
      chk("t6_held_grant", 64'(m_grant), 64'(0));
      @(negedge clk);
      reset_n = 1'b1;
      expect_beat(0);
      tick();
      chk("t6_ptr_reset_grant", 64'(m_grant), 64'(3'b001));
      m_req = 3'b000;
      tick();
      chk("t6_end_valid", 64'(s_valid), 64'(0));

      chk("sb_drain", 64'(sb.size()), 64'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
